// File: rtl/frac_pll_pkg.sv
// Shared constants for the fractional-N loop: divider moduli, select encodings
// and the dither LFSR polynomial.
package frac_pll_pkg;

  localparam int unsigned DIV_MOD_LO = 240;
  localparam int unsigned DIV_MOD_HI = 248;

  localparam logic SEL_DIV240 = 1'b1;
  localparam logic SEL_DIV248 = 1'b0;

  localparam int unsigned LFSR_WIDTH = 15;
  // Polynomial form: bit 14 is x^15, bit 13 is x^14 (x^15 + x^14 + 1).
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 15'h6000;

  // The register shifts toward bit 0, so the tap mask on the state is the mirror
  // of the polynomial mask.
  function automatic logic [LFSR_WIDTH-1:0] poly_to_state_taps(
    input logic [LFSR_WIDTH-1:0] poly
  );
    logic [LFSR_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LFSR_WIDTH; i++) begin
      r[i] = poly[LFSR_WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/frac_modulus_controller_if.sv
// Control/status bundle between the loop controller and the modulus controller.
interface frac_modulus_controller_if #(
  parameter int unsigned ACC_WIDTH = 16
);
  logic                 enable;
  logic [ACC_WIDTH-1:0] frac_word;
  logic                 frac_load;
  logic                 dither_en;
  logic                 select_mode;
  logic [ACC_WIDTH-1:0] frac_active;
  logic                 update_pending;

  modport master (
    output enable, frac_word, frac_load, dither_en,
    input  select_mode, frac_active, update_pending
  );

  modport slave (
    input  enable, frac_word, frac_load, dither_en,
    output select_mode, frac_active, update_pending
  );
endinterface

// File: rtl/frac_modulus_controller_lfsr_dither.sv
// 15-bit Fibonacci LFSR supplying one dither bit per advance.
module lfsr_dither
  import frac_pll_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = 15'h4A5B
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  output logic bit_out
);

  localparam logic [LFSR_WIDTH-1:0] FB_MASK = poly_to_state_taps(LFSR_TAPS);

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic                  feedback;

  always_comb begin
    feedback = ^(lfsr_q & FB_MASK);
    lfsr_d   = lfsr_q;
    if (advance) begin
      lfsr_d = {feedback, lfsr_q[LFSR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_out = lfsr_q[0];

endmodule

// File: rtl/frac_modulus_controller.sv
// First-order delta-sigma modulus controller: the accumulator carry picks the
// divider modulus for the next division cycle.
module frac_modulus_controller
  import frac_pll_pkg::*;
#(
  parameter int unsigned           ACC_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 15'h4A5B
) (
  input  logic                        freq_in,
  input  logic                        reset,
  frac_modulus_controller_if.slave    bus
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] frac_active_q, frac_active_d;
  logic [ACC_WIDTH-1:0] frac_shadow_q, frac_shadow_d;
  logic                 update_pending_q, update_pending_d;
  logic                 select_mode_q, select_mode_d;
  logic                 dither_bit, d_bit, carry, apply, lfsr_advance;
  logic [ACC_WIDTH:0]   sum;

  lfsr_dither #(
    .SEED (LFSR_SEED)
  ) u_dither (
    .clk     (freq_in),
    .rst_n   (reset),
    .advance (lfsr_advance),
    .bit_out (dither_bit)
  );

  assign lfsr_advance = bus.enable & bus.dither_en;

  always_comb begin
    d_bit = bus.dither_en & dither_bit;
    sum   = {1'b0, acc_q} + {1'b0, frac_active_q} + {{ACC_WIDTH{1'b0}}, d_bit};
    carry = sum[ACC_WIDTH];

    acc_d            = acc_q;
    select_mode_d    = SEL_DIV248;
    frac_active_d    = frac_active_q;
    frac_shadow_d    = frac_shadow_q;
    update_pending_d = update_pending_q;

    if (bus.enable) begin
      acc_d         = sum[ACC_WIDTH-1:0];
      select_mode_d = carry ? SEL_DIV240 : SEL_DIV248;
    end

    // Swap only at a carry, an idle word or while stopped, so the ratio change
    // lands on an accumulator wrap boundary.
    apply = update_pending_q & (~bus.enable | carry | (frac_active_q == '0));
    if (apply) begin
      frac_active_d    = frac_shadow_q;
      update_pending_d = 1'b0;
    end

    // A coincident load re-arms after the old shadow has been applied.
    if (bus.frac_load) begin
      frac_shadow_d    = bus.frac_word;
      update_pending_d = 1'b1;
    end
  end

  always_ff @(posedge freq_in or negedge reset) begin
    if (!reset) begin
      acc_q            <= '0;
      frac_active_q    <= '0;
      frac_shadow_q    <= '0;
      update_pending_q <= 1'b0;
      select_mode_q    <= SEL_DIV248;
    end else begin
      acc_q            <= acc_d;
      frac_active_q    <= frac_active_d;
      frac_shadow_q    <= frac_shadow_d;
      update_pending_q <= update_pending_d;
      select_mode_q    <= select_mode_d;
    end
  end

  assign bus.select_mode    = select_mode_q;
  assign bus.frac_active    = frac_active_q;
  assign bus.update_pending = update_pending_q;

endmodule

// File: tb/tb_frac_modulus_controller.sv
// Directed bench for frac_modulus_controller at ACC_WIDTH=4.
module tb_frac_modulus_controller;
  import frac_pll_pkg::*;

  localparam int unsigned AW = 4;
  localparam logic [14:0] SEED = 15'h4A5B;

  logic freq_in = 1'b0;
  logic reset   = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   cnt;

  frac_modulus_controller_if #(.ACC_WIDTH(AW)) bus ();

  frac_modulus_controller #(
    .ACC_WIDTH (AW),
    .LFSR_SEED (SEED)
  ) dut (
    .freq_in (freq_in),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 freq_in = ~freq_in;

  task automatic tick();
    @(posedge freq_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.frac_word = '0;
    bus.frac_load = 1'b0;
    bus.dither_en = 1'b0;

    // Reset state before any clock edge
    #2;
    chk("rst_sel", 32'(bus.select_mode), 32'd0);
    chk("rst_active", 32'(bus.frac_active), 32'd0);
    chk("rst_pending", 32'(bus.update_pending), 32'd0);
    #5 reset = 1'b1;

    // frac=4: load, pending, apply on idle word, then 0,0,0,1 pattern
    bus.enable = 1'b1; bus.frac_word = 4'd4; bus.frac_load = 1'b1;
    tick();
    chk("ld4_pending", 32'(bus.update_pending), 32'd1);
    chk("ld4_active_old", 32'(bus.frac_active), 32'd0);
    bus.frac_load = 1'b0;
    tick();
    chk("ld4_active", 32'(bus.frac_active), 32'd4);
    chk("ld4_cleared", 32'(bus.update_pending), 32'd0);
    chk("ld4_sel_apply", 32'(bus.select_mode), 32'd0);
    cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("f4_seq", 32'(bus.select_mode), (k % 4 == 0) ? 32'd1 : 32'd0);
      cnt += int'(bus.select_mode);
    end
    chk("f4_ones", 32'(cnt), 32'd4);
    chk("f4_acc_wrap", 32'(dut.acc_q), 32'd0);

    // Load 8 while acc=4; applies on the carry edge
    tick();
    chk("c_pre_sel", 32'(bus.select_mode), 32'd0);
    bus.frac_word = 4'd8; bus.frac_load = 1'b1;
    tick();
    chk("c_pending", 32'(bus.update_pending), 32'd1);
    chk("c_active_hold", 32'(bus.frac_active), 32'd4);
    bus.frac_load = 1'b0;
    tick();
    chk("c_wait_active", 32'(bus.frac_active), 32'd4);
    chk("c_wait_sel", 32'(bus.select_mode), 32'd0);
    tick();
    chk("c_carry_sel", 32'(bus.select_mode), 32'd1);
    chk("c_active8", 32'(bus.frac_active), 32'd8);
    chk("c_cleared", 32'(bus.update_pending), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("f8_seq", 32'(bus.select_mode), (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Disable with acc=8, coincident load while stopped, then resume
    tick();
    chk("d_pre_sel", 32'(bus.select_mode), 32'd0);
    bus.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("d_off_sel", 32'(bus.select_mode), 32'd0);
    end
    chk("d_acc_frozen", 32'(dut.acc_q), 32'd8);
    bus.frac_word = 4'd5; bus.frac_load = 1'b1;
    tick();
    chk("d_pend5", 32'(bus.update_pending), 32'd1);
    chk("d_act8", 32'(bus.frac_active), 32'd8);
    bus.frac_word = 4'd6;
    tick();
    chk("d_coinc_act5", 32'(bus.frac_active), 32'd5);
    chk("d_coinc_pend", 32'(bus.update_pending), 32'd1);
    bus.frac_load = 1'b0;
    tick();
    chk("d_act6", 32'(bus.frac_active), 32'd6);
    chk("d_pend_clr", 32'(bus.update_pending), 32'd0);
    bus.enable = 1'b1;
    // acc 8 -> 14, 4(c), 10, 0(c)
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("d_resume_seq", 32'(bus.select_mode), (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Fresh reset, frac=15: one zero per 16 edges
    reset = 1'b0; #1;
    @(negedge freq_in) reset = 1'b1;
    bus.frac_word = 4'd15; bus.frac_load = 1'b1;
    tick();
    bus.frac_load = 1'b0;
    tick();
    chk("f15_active", 32'(bus.frac_active), 32'd15);
    cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("f15_seq", 32'(bus.select_mode), (k == 1) ? 32'd0 : 32'd1);
      if (bus.select_mode == 1'b0) cnt++;
    end
    chk("f15_zeros", 32'(cnt), 32'd1);
    for (int k = 1; k <= 4; k++) tick();
    chk("r_pre_acc", 32'(dut.acc_q), 32'd12);
    chk("r_pre_sel", 32'(bus.select_mode), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("r_async_sel", 32'(bus.select_mode), 32'd0);
    chk("r_async_active", 32'(bus.frac_active), 32'd0);
    chk("r_async_acc", 32'(dut.acc_q), 32'd0);
    @(negedge freq_in) reset = 1'b1;
    bus.frac_word = 4'd4; bus.frac_load = 1'b1;
    tick();
    bus.frac_load = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("r_restart_seq", 32'(bus.select_mode), (k == 4) ? 32'd1 : 32'd0);
    end

    // frac=0, dither off: never a carry
    reset = 1'b0; #1;
    @(negedge freq_in) reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      cnt += int'(bus.select_mode);
    end
    chk("f0_no_carry", 32'(cnt), 32'd0);

    // frac=0, dither on for a full LFSR period: 2^14 ones -> 1024 carries
    bus.dither_en = 1'b1;
    cnt = 0;
    for (int k = 0; k < 32767; k++) begin
      tick();
      cnt += int'(bus.select_mode);
    end
    chk("dith_carries", 32'(cnt), 32'd1024);
    chk("dith_lfsr_period", 32'(dut.u_dither.lfsr_q), 32'(SEED));
    chk("dith_acc_end", 32'(dut.acc_q), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
